// File: rtl/adder_arb_pkg.sv
// Shared constants and the stage-1 bundle for the round-robin adder arbiter.
// The id field is sized for the widest tag the arbiter supports.
package adder_arb_pkg;

   localparam int OP_W        = 4;
   localparam int SUM_W       = 5;
   localparam int DEF_NUM_REQ = 4;
   localparam int MAX_ID_W    = 8;

   typedef struct packed {
      logic                valid;
      logic [OP_W-1:0]     a;
      logic [OP_W-1:0]     b;
      logic [MAX_ID_W-1:0] id;
   } s1_entry_t;

   // Next index after p, wrapping at n.
   function automatic int wrap_inc(input int p, input int n);
      return (p + 1) % n;
   endfunction

endpackage

// File: rtl/adder.sv
// Shared 4-bit adder; the carry-out lands in bit 4 of the sum.
// Purely combinational.
module adder
   import adder_arb_pkg::*;
(
   input  logic [OP_W-1:0]  a,
   input  logic [OP_W-1:0]  b,
   output logic [SUM_W-1:0] sum
);

   assign sum = {1'b0, a} + {1'b0, b};

endmodule

// File: rtl/adder_arbiter_rr_arbiter.sv
// Combinational round-robin picker; the caller owns the pointer register.
// The search begins one past ptr and wraps.
module rr_arbiter
   import adder_arb_pkg::*;
#(
   parameter  int N  = DEF_NUM_REQ,
   localparam int IW = $clog2(N)
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] ptr,
   input  logic          en,
   output logic [N-1:0]  gnt,
   output logic [IW-1:0] gnt_idx
);

   int   idx;
   logic found;

   always_comb begin
      gnt     = '0;
      gnt_idx = '0;
      found   = 1'b0;
      idx     = int'(ptr);
      for (int i = 0; i < N; i++) begin
         idx = wrap_inc(idx, N);
         if (en && !found && req[idx]) begin
            found    = 1'b1;
            gnt[idx] = 1'b1;
            gnt_idx  = IW'(idx);
         end
      end
   end

endmodule

// File: rtl/adder_arbiter.sv
// Round-robin front end for one shared adder: operand capture (S1),
// result register (S2), tagged output with valid/ready backpressure.
module adder_arbiter
   import adder_arb_pkg::*;
#(
   parameter  int NUM_REQ = DEF_NUM_REQ,
   localparam int ID_W    = $clog2(NUM_REQ)
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [NUM_REQ-1:0]      req,
   input  logic [OP_W*NUM_REQ-1:0] req_a,
   input  logic [OP_W*NUM_REQ-1:0] req_b,
   output logic [NUM_REQ-1:0]      gnt,
   output logic                    rsp_valid,
   input  logic                    rsp_ready,
   output logic [ID_W-1:0]         rsp_id,
   output logic [SUM_W-1:0]        rsp_sum
);

   logic [ID_W-1:0]  ptr;
   logic [ID_W-1:0]  gnt_idx;
   logic             out_free;
   logic             s1_adv;
   logic             accept;
   logic             arb_en;
   logic             granted;
   logic [OP_W-1:0]  sel_a;
   logic [OP_W-1:0]  sel_b;
   logic [SUM_W-1:0] sum;
   s1_entry_t        s1_q;

   assign out_free = !rsp_valid || rsp_ready;
   assign s1_adv   = s1_q.valid && out_free;
   assign accept   = !s1_q.valid || s1_adv;
   // Masking with rst keeps gnt low for the whole reset window.
   assign arb_en   = accept && !rst;
   assign granted  = |gnt;

   rr_arbiter #(
      .N (NUM_REQ)
   ) u_arb (
      .req     (req),
      .ptr     (ptr),
      .en      (arb_en),
      .gnt     (gnt),
      .gnt_idx (gnt_idx)
   );

   assign sel_a = req_a[gnt_idx*OP_W +: OP_W];
   assign sel_b = req_b[gnt_idx*OP_W +: OP_W];

   adder u_adder (
      .a   (s1_q.a),
      .b   (s1_q.b),
      .sum (sum)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ptr <= ID_W'(NUM_REQ - 1);
      end else if (granted) begin
         ptr <= gnt_idx;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_q <= '0;
      end else if (granted) begin
         s1_q.valid <= 1'b1;
         s1_q.a     <= sel_a;
         s1_q.b     <= sel_b;
         s1_q.id    <= MAX_ID_W'(gnt_idx);
      end else if (s1_adv) begin
         s1_q.valid <= 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rsp_valid <= 1'b0;
         rsp_id    <= '0;
         rsp_sum   <= '0;
      end else if (s1_adv) begin
         rsp_valid <= 1'b1;
         rsp_id    <= ID_W'(s1_q.id);
         rsp_sum   <= sum;
      end else if (rsp_valid && rsp_ready) begin
         rsp_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_adder_arbiter.sv
// Scoreboard bench for adder_arbiter: grants push expected results,
// accepted responses pop and compare.
module tb_adder_arbiter;

   typedef struct {
      logic [1:0] id;
      logic [4:0] sum;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [3:0]  req = '0;
   logic [15:0] req_a;
   logic [15:0] req_b;
   logic [3:0]  gnt;
   logic        rsp_valid;
   logic        rsp_ready = 1'b1;
   logic [1:0]  rsp_id;
   logic [4:0]  rsp_sum;

   logic [3:0]  op_a [4];
   logic [3:0]  op_b [4];
   exp_t        sb [$];
   int          n_vec = 0;
   int          n_bad = 0;

   always #5 clk = ~clk;

   always_comb begin
      req_a = {op_a[3], op_a[2], op_a[1], op_a[0]};
      req_b = {op_b[3], op_b[2], op_b[1], op_b[0]};
   end

   adder_arbiter #(
      .NUM_REQ (4)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .req       (req),
      .req_a     (req_a),
      .req_b     (req_b),
      .gnt       (gnt),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_id    (rsp_id),
      .rsp_sum   (rsp_sum)
   );

   task automatic check(input string tag, input logic [31:0] obs,
                        input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d want %0d at %0t", tag, obs, exp, $time);
      end
   endtask

   // Scoreboard: pop/compare the head, then push any new grant.
   always @(negedge clk) begin
      if (!rst) begin
         if (rsp_valid) begin
            if (sb.size() == 0) begin
               check("spurious_rsp", 32'(rsp_valid), 32'd0);
            end else begin
               check("sb_id", 32'(rsp_id), 32'(sb[0].id));
               check("sb_sum", 32'(rsp_sum), 32'(sb[0].sum));
               if (rsp_ready) void'(sb.pop_front());
            end
         end
         if (gnt != '0) begin
            exp_t e;
            check("gnt_onehot", 32'($countones(gnt)), 32'd1);
            e.id  = '0;
            e.sum = '0;
            for (int i = 0; i < 4; i++) begin
               if (gnt[i]) begin
                  e.id  = 2'(i);
                  e.sum = 5'(op_a[i]) + 5'(op_b[i]);
               end
            end
            sb.push_back(e);
         end
      end
   end

   task automatic apply_reset();
      rst = 1'b1;
      req = '0;
      sb.delete();
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst = 1'b0;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while ((sb.size() != 0 || rsp_valid) && n < 40) begin
         @(negedge clk);
         n++;
      end
      check("drain_empty", 32'(sb.size()), 32'd0);
      check("drain_idle", 32'(rsp_valid), 32'd0);
      @(posedge clk); #1;
   endtask

   // One cycle: sample gnt mid-cycle, then withdraw granted requests.
   task automatic cyc(output logic [3:0] g);
      @(negedge clk);
      g = gnt;
      @(posedge clk); #1;
      req = req & ~g;
   endtask

   task automatic single(input int k, input logic [3:0] a,
                         input logic [3:0] b, input logic [4:0] exp_sum);
      op_a[k] = a;
      op_b[k] = b;
      req = 4'(1 << k);
      @(negedge clk);
      check("single_gnt", 32'(gnt), 32'(1 << k));
      @(posedge clk); #1;
      req = '0;
      @(negedge clk);
      check("single_lat", 32'(rsp_valid), 32'd0);
      @(negedge clk);
      check("single_valid", 32'(rsp_valid), 32'd1);
      check("single_sum", 32'(rsp_sum), 32'(exp_sum));
      check("single_id", 32'(rsp_id), 32'(k));
      @(negedge clk);
      check("single_done", 32'(rsp_valid), 32'd0);
      @(posedge clk); #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want completion");
      $fatal(1);
   end

   initial begin
      logic [3:0] g;
      int         gl [$];
      int         n;
      int         exp_rr [5];
      exp_rr = '{0, 1, 2, 3, 0};
      for (int i = 0; i < 4; i++) begin
         op_a[i] = '0;
         op_b[i] = '0;
      end

      // Reset state, gnt held low even with requests present.
      req = 4'b1111;
      @(negedge clk);
      check("rst_valid", 32'(rsp_valid), 32'd0);
      check("rst_id", 32'(rsp_id), 32'd0);
      check("rst_sum", 32'(rsp_sum), 32'd0);
      check("rst_gnt", 32'(gnt), 32'd0);
      apply_reset();

      // Single request latency, then arithmetic corners.
      single(0, 4'd3, 4'd4, 5'd7);
      single(0, 4'd15, 4'd15, 5'd30);
      single(0, 4'd0, 4'd0, 5'd0);
      single(0, 4'd8, 4'd8, 5'd16);
      drain();

      // Round robin from reset pointer, back-to-back results.
      apply_reset();
      for (int i = 0; i < 4; i++) begin
         op_a[i] = 4'(i);
         op_b[i] = 4'd15;
      end
      req = 4'b1111;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("rr_order", 32'(gnt), 32'(1 << exp_rr[i]));
         if (i >= 2) check("rr_b2b", 32'(rsp_valid), 32'd1);
         @(posedge clk); #1;
      end
      req = '0;
      @(negedge clk);
      check("rr_b2b", 32'(rsp_valid), 32'd1);
      check("rr_stop", 32'(gnt), 32'd0);
      @(negedge clk);
      check("rr_b2b", 32'(rsp_valid), 32'd1);
      @(negedge clk);
      check("rr_end", 32'(rsp_valid), 32'd0);
      @(posedge clk); #1;
      drain();

      // Backpressure: two grants fill S1/S2, then the arbiter stalls.
      apply_reset();
      rsp_ready = 1'b0;
      op_a[0] = 4'd1;  op_b[0] = 4'd2;
      op_a[1] = 4'd9;  op_b[1] = 4'd9;
      op_a[2] = 4'd14; op_b[2] = 4'd5;
      req = 4'b0111;
      gl.delete();
      for (int c = 0; c < 6; c++) begin
         cyc(g);
         if (c >= 2) check("bp_gnt_zero", 32'(g), 32'd0);
         for (int i = 0; i < 4; i++) if (g[i]) gl.push_back(i);
      end
      check("bp_two_grants", 32'(gl.size()), 32'd2);
      rsp_ready = 1'b1;
      n = 0;
      while ((req != '0 || sb.size() != 0 || rsp_valid) && n < 30) begin
         cyc(g);
         for (int i = 0; i < 4; i++) if (g[i]) gl.push_back(i);
         n++;
      end
      check("bp_total_grants", 32'(gl.size()), 32'd3);
      for (int i = 0; i < gl.size() && i < 3; i++)
         check("bp_order", 32'(gl[i]), 32'(i));
      drain();

      // Reset with S1 and S2 both occupied.
      apply_reset();
      rsp_ready = 1'b0;
      op_a[0] = 4'd5; op_b[0] = 4'd6;
      op_a[1] = 4'd7; op_b[1] = 4'd1;
      req = 4'b0011;
      cyc(g);
      cyc(g);
      @(negedge clk);
      check("pre_rst_valid", 32'(rsp_valid), 32'd1);
      #2;
      rst = 1'b1;
      req = 4'b1001;
      #1;
      check("async_rst_valid", 32'(rsp_valid), 32'd0);
      check("async_rst_gnt", 32'(gnt), 32'd0);
      sb.delete();
      req = '0;
      @(posedge clk); #1;
      rst = 1'b0;
      rsp_ready = 1'b1;
      op_a[3] = 4'd2; op_b[3] = 4'd2;
      req = 4'b1001;
      @(negedge clk);
      check("post_rst_first", 32'(gnt), 32'b0001);
      @(posedge clk); #1;
      req = 4'b1000;
      @(negedge clk);
      check("post_rst_second", 32'(gnt), 32'b1000);
      @(posedge clk); #1;
      req = '0;
      drain();

      // Fairness between two, then a lone requester every cycle.
      apply_reset();
      req = 4'b0011;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check("fair_alt", 32'(gnt), (i % 2) ? 32'b0010 : 32'b0001);
         @(posedge clk); #1;
      end
      req = 4'b0001;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("fair_solo", 32'(gnt), 32'b0001);
         @(posedge clk); #1;
      end
      req = '0;
      drain();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
